// File: rtl/udp_echo_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_echo_buffer_pkg
// Description : Shared FSM encodings, default sizing and helpers for the UDP
//               store-and-forward echo buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_echo_buffer_pkg;

    localparam int C_MAX_LEN = 1472;
    localparam int C_ADDR_W  = 11;
    localparam int C_GAP     = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RECV     = 3'd1,
        ST_DROP     = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_SEND     = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_echo_ram.sv
`default_nettype none
// ============================================================================
// Module      : udp_echo_ram
// Description : Simple dual-port byte RAM with a registered read port (BRAM).
// Revision    : 1.0 - initial release
// ============================================================================
module udp_echo_ram #(
    parameter int P_ADDR_W = 11
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [P_ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]          i_wr_data,
    input  logic [P_ADDR_W-1:0] i_rd_addr,
    output logic [7:0]          o_rd_data
);

    logic [7:0] r_mem [0:(2**P_ADDR_W)-1];

    // No reset on the array or read register so the tools can map it to BRAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/udp_echo_buffer.sv
`default_nettype none
// ============================================================================
// Module      : udp_echo_buffer
// Description : Captures one received UDP payload and replays it to the send
//               port once the stack reports ready.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_echo_buffer
    import udp_echo_buffer_pkg::*;
#(
    parameter int P_MAX_LEN = C_MAX_LEN,
    parameter int P_ADDR_W  = C_ADDR_W,
    parameter int P_GAP     = C_GAP
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_recv_udp_data,
    input  logic [15:0] i_recv_udp_len,
    input  logic        i_recv_udp_last,
    input  logic        i_recv_udp_valid,
    input  logic        i_send_ready,
    output logic [7:0]  o_send_udp_data,
    output logic [15:0] o_send_udp_len,
    output logic        o_send_udp_last,
    output logic        o_send_udp_valid,
    output logic        o_busy,
    output logic [15:0] o_drop_cnt
);

    localparam int             CW           = P_ADDR_W + 1;
    localparam logic [CW-1:0]  C_MAX_CNT    = CW'(P_MAX_LEN);
    localparam logic [CW-1:0]  C_GAP_LAST   = CW'(P_GAP - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_wr_cnt;
    logic [CW-1:0]       r_len;
    logic [CW-1:0]       r_out_idx;
    logic [CW-1:0]       r_gap_cnt;
    logic [CW-1:0]       w_wr_cnt_inc;
    logic                r_rx_discard;
    logic [15:0]         r_drop_cnt;
    logic                w_wr_en;
    logic                w_drop_inc;
    logic                w_rx_busy;
    logic                w_sending;
    logic                w_send_last;
    logic [P_ADDR_W-1:0] w_wr_addr;
    logic [P_ADDR_W-1:0] w_rd_addr;
    logic [7:0]          w_rd_data;
    logic                w_unused_len;

    // The declared length is informational; the echoed length is the byte count.
    assign w_unused_len = ^i_recv_udp_len;

    assign w_sending    = (r_state == ST_SEND);
    assign w_send_last  = w_sending && (r_out_idx == r_len - CW'(1));
    assign w_rx_busy    = (r_state == ST_WAIT_RDY) || (r_state == ST_SEND) || (r_state == ST_GAP);
    assign w_wr_cnt_inc = (r_state == ST_RECV) ? r_wr_cnt + CW'(1) : CW'(1);
    assign w_wr_addr    = (r_state == ST_RECV) ? r_wr_cnt[P_ADDR_W-1:0] : '0;
    // Read address runs one ahead of the output index; address 0 is prefetched outside SEND.
    assign w_rd_addr    = w_sending ? r_out_idx[P_ADDR_W-1:0] + P_ADDR_W'(1) : '0;

    udp_echo_ram #(
        .P_ADDR_W (P_ADDR_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_recv_udp_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // While tail bytes of a discarded packet are still arriving, do not restart.
                if (i_recv_udp_valid && !r_rx_discard) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = i_recv_udp_last ? ST_WAIT_RDY : ST_RECV;
                end
            end
            ST_RECV: begin
                if (!i_recv_udp_valid) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_wr_cnt >= C_MAX_CNT) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = i_recv_udp_last ? ST_IDLE : ST_DROP;
                end else begin
                    w_wr_en = 1'b1;
                    if (i_recv_udp_last) begin
                        w_state_nxt = ST_WAIT_RDY;
                    end
                end
            end
            ST_DROP: begin
                if (!i_recv_udp_valid || i_recv_udp_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                if (i_send_ready) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_send_last) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == C_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_rx_busy && i_recv_udp_valid && !r_rx_discard) begin
            w_drop_inc = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt     <= '0;
            r_len        <= '0;
            r_out_idx    <= '0;
            r_gap_cnt    <= '0;
            r_rx_discard <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_cnt <= w_wr_cnt_inc;
                if (i_recv_udp_last) begin
                    r_len <= w_wr_cnt_inc;
                end
            end
            r_out_idx <= (w_sending && !w_send_last) ? r_out_idx + CW'(1) : '0;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + CW'(1) : '0;
            // Tracks a packet arriving while the buffer is owned by the send side.
            if (r_rx_discard) begin
                if (!i_recv_udp_valid || i_recv_udp_last) begin
                    r_rx_discard <= 1'b0;
                end
            end else if (w_rx_busy && i_recv_udp_valid && !i_recv_udp_last) begin
                r_rx_discard <= 1'b1;
            end
            if (w_drop_inc) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
        end
    end

    assign o_send_udp_valid = w_sending;
    assign o_send_udp_last  = w_send_last;
    assign o_send_udp_data  = w_sending ? w_rd_data : 8'd0;
    assign o_send_udp_len   = 16'(r_len);
    assign o_busy           = (r_state != ST_IDLE);
    assign o_drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire
